read_b_out: RTL

READ_B_OUT -- requirements
Module: read_b_out

---
 rtl/read_b_out.sv | 69 ++++++
 1 files changed

// File: rtl/read_b_out.sv
// Drains a standard (non-FWFT) FIFO and wraps each word in a fixed {leaf, port} header
// for the NoC leaf interface, holding every packet until downstream accepts it.
module read_b_out #(
   parameter int unsigned PAYLOAD_BITS = 64,
   parameter int unsigned ADDR_BITS    = 5,
   parameter int unsigned PORT_BITS    = 4,
   parameter int unsigned DST_LEAF     = 1,
   parameter int unsigned DST_PORT     = 2,
   parameter int unsigned CNT_BITS     = 32
) (
   input  logic                                      clk,
   input  logic                                      reset,
   input  logic                                      empty,
   input  logic [PAYLOAD_BITS-1:0]                   dout,
   output logic                                      rd_en,
   input  logic                                      ready,
   output logic                                      vld_out,
   output logic [ADDR_BITS+PORT_BITS+PAYLOAD_BITS-1:0] dout_leaf_interface2noc,
   output logic [CNT_BITS-1:0]                       sent_count
);

   localparam logic [ADDR_BITS-1:0] LEAF = ADDR_BITS'(DST_LEAF);
   localparam logic [PORT_BITS-1:0] PORT = PORT_BITS'(DST_PORT);

   typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;

   state_t                  state;
   logic [PAYLOAD_BITS-1:0] payload;
   logic                    accept;

   assign accept = (state == SEND) && ready;

   // Pop in IDLE, or in SEND on the same cycle the current packet is accepted.
   assign rd_en = !reset && !empty && ((state == IDLE) || accept);

   assign dout_leaf_interface2noc = {LEAF, PORT, payload};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         vld_out    <= 1'b0;
         payload    <= '0;
         sent_count <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (!empty) state <= FETCH;
            end
            FETCH: begin
               payload <= dout;
               vld_out <= 1'b1;
               state   <= SEND;
            end
            SEND: begin
               if (ready) begin
                  sent_count <= sent_count + 1'b1;
                  vld_out    <= 1'b0;
                  state      <= empty ? IDLE : FETCH;
               end
            end
            default: begin
               state   <= IDLE;
               vld_out <= 1'b0;
            end
         endcase
      end
   end

endmodule
